// File: rtl/plot_arbiter.sv
// Three-requester round-robin arbiter that multiplexes pixel writes onto one
// VGA adapter port. Optional watchdog enabled by defining PLOT_ARB_TIMEOUT_EN.
module plot_arbiter (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] req,
    input  logic [7:0] x0,
    input  logic [7:0] x1,
    input  logic [7:0] x2,
    input  logic [6:0] y0,
    input  logic [6:0] y1,
    input  logic [6:0] y2,
    input  logic [2:0] colour0,
    input  logic [2:0] colour1,
    input  logic [2:0] colour2,
    input  logic       plot0,
    input  logic       plot1,
    input  logic       plot2,
    output logic [2:0] gnt,
    output logic [7:0] out_x,
    output logic [6:0] out_y,
    output logic [2:0] out_colour,
    output logic       plot,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANTED = 2'd1,
        GAP     = 2'd2
    } state_t;

    localparam logic [7:0] X_MAX = 8'd159;
    localparam logic [6:0] Y_MAX = 7'd119;

    state_t     state;
    logic [1:0] win;
    logic [1:0] last_winner;

    // (base + off) mod 3 for base, off in 0..2
    function automatic logic [1:0] rr_index(input logic [1:0] base, input logic [1:0] off);
        logic [2:0] sum;
        sum = {1'b0, base} + {1'b0, off};
        return (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
    endfunction

    logic [1:0] start;
    logic [1:0] cand [3];
    logic [1:0] pick;
    logic       pick_valid;

    assign start = (last_winner >= 2'd2) ? 2'd0 : last_winner + 2'd1;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cand
            assign cand[gi] = rr_index(start, 2'(gi));
        end
    endgenerate

    always_comb begin
        pick       = start;
        pick_valid = 1'b0;
        if (req[cand[0]]) begin
            pick       = cand[0];
            pick_valid = 1'b1;
        end else if (req[cand[1]]) begin
            pick       = cand[1];
            pick_valid = 1'b1;
        end else if (req[cand[2]]) begin
            pick       = cand[2];
            pick_valid = 1'b1;
        end
    end

    logic       sel_req;
    logic [7:0] sel_x;
    logic [6:0] sel_y;
    logic [2:0] sel_colour;
    logic       sel_plot;
    logic       on_screen;

    always_comb begin
        sel_req    = req[2];
        sel_x      = x2;
        sel_y      = y2;
        sel_colour = colour2;
        sel_plot   = plot2;
        case (win)
            2'd0: begin
                sel_req    = req[0];
                sel_x      = x0;
                sel_y      = y0;
                sel_colour = colour0;
                sel_plot   = plot0;
            end
            2'd1: begin
                sel_req    = req[1];
                sel_x      = x1;
                sel_y      = y1;
                sel_colour = colour1;
                sel_plot   = plot1;
            end
            default: ;
        endcase
    end

    assign on_screen = (sel_x <= X_MAX) && (sel_y <= Y_MAX);
    assign busy      = (state != IDLE);

`ifdef PLOT_ARB_TIMEOUT_EN
    logic [11:0] wd_count;
    logic        wd_expire;
    logic        timeout_reg;

    assign wd_expire = (wd_count == 12'hFFF);
    assign timeout   = timeout_reg;
`else
    logic wd_expire;

    assign wd_expire = 1'b0;
    assign timeout   = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            win         <= 2'd0;
            last_winner <= 2'd2;
            gnt         <= 3'b000;
            plot        <= 1'b0;
            out_x       <= 8'd0;
            out_y       <= 7'd0;
            out_colour  <= 3'd0;
`ifdef PLOT_ARB_TIMEOUT_EN
            wd_count    <= 12'd0;
            timeout_reg <= 1'b0;
`endif
        end else begin
`ifdef PLOT_ARB_TIMEOUT_EN
            timeout_reg <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    plot <= 1'b0;
                    if (pick_valid) begin
                        state <= GRANTED;
                        win   <= pick;
                        gnt   <= 3'b001 << pick;
`ifdef PLOT_ARB_TIMEOUT_EN
                        wd_count <= 12'd0;
`endif
                    end else begin
                        gnt <= 3'b000;
                    end
                end
                GRANTED: begin
                    if (!sel_req) begin
                        // Strobe in the release cycle is discarded on purpose.
                        state <= GAP;
                        gnt   <= 3'b000;
                        plot  <= 1'b0;
                    end else if (wd_expire) begin
                        state <= GAP;
                        gnt   <= 3'b000;
                        plot  <= 1'b0;
`ifdef PLOT_ARB_TIMEOUT_EN
                        timeout_reg <= 1'b1;
`endif
                    end else begin
                        out_x      <= sel_x;
                        out_y      <= sel_y;
                        out_colour <= sel_colour;
                        plot       <= sel_plot && on_screen;
`ifdef PLOT_ARB_TIMEOUT_EN
                        wd_count   <= wd_count + 12'd1;
`endif
                    end
                end
                GAP: begin
                    last_winner <= win;
                    state       <= IDLE;
                    gnt         <= 3'b000;
                    plot        <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    gnt   <= 3'b000;
                    plot  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_plot_arbiter.sv
// Directed self-checking bench for plot_arbiter; the watchdog scenario follows
// whichever way PLOT_ARB_TIMEOUT_EN is set for the build.
module tb_plot_arbiter;

    logic       clock;
    logic       reset;
    logic [2:0] req;
    logic [7:0] x0, x1, x2;
    logic [6:0] y0, y1, y2;
    logic [2:0] colour0, colour1, colour2;
    logic       plot0, plot1, plot2;
    logic [2:0] gnt;
    logic [7:0] out_x;
    logic [6:0] out_y;
    logic [2:0] out_colour;
    logic       plot;
    logic       busy;
    logic       timeout;

    int n_checks = 0;
    int n_fail   = 0;

    plot_arbiter dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .x0         (x0),
        .x1         (x1),
        .x2         (x2),
        .y0         (y0),
        .y1         (y1),
        .y2         (y2),
        .colour0    (colour0),
        .colour1    (colour1),
        .colour2    (colour2),
        .plot0      (plot0),
        .plot1      (plot1),
        .plot2      (plot2),
        .gnt        (gnt),
        .out_x      (out_x),
        .out_y      (out_y),
        .out_colour (out_colour),
        .plot       (plot),
        .busy       (busy),
        .timeout    (timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        n_checks++; if (gnt !== 3'b000) begin n_fail++; $display("FAIL reset_gnt got %b want 000", gnt); end
        n_checks++; if (plot !== 1'b0) begin n_fail++; $display("FAIL reset_plot got %b want 0", plot); end
        n_checks++; if (out_x !== 8'd0) begin n_fail++; $display("FAIL reset_out_x got %0d want 0", out_x); end
        n_checks++; if (out_y !== 7'd0) begin n_fail++; $display("FAIL reset_out_y got %0d want 0", out_y); end
        n_checks++; if (out_colour !== 3'd0) begin n_fail++; $display("FAIL reset_colour got %0d want 0", out_colour); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout got %b want 0", timeout); end
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        tick();
        n_checks++; if (gnt !== 3'b000 || busy !== 1'b0) begin n_fail++; $display("FAIL idle_no_req got gnt=%b busy=%b want 000/0", gnt, busy); end
        $display("test_reset done");
    endtask

    // Burst sequence: 111 -> grant 0, then 1, then 2, then 0 again.
    task automatic test_round_robin();
        req = 3'b111;
        tick();
        n_checks++; if (gnt !== 3'b001 || busy !== 1'b1) begin n_fail++; $display("FAIL rr_first got gnt=%b busy=%b want 001/1", gnt, busy); end
        tick();
        n_checks++; if (gnt !== 3'b001) begin n_fail++; $display("FAIL rr_hold got %b want 001", gnt); end
        req = 3'b110;
        tick();
        n_checks++; if (gnt !== 3'b000 || busy !== 1'b1) begin n_fail++; $display("FAIL rr_gap got gnt=%b busy=%b want 000/1", gnt, busy); end
        tick();
        n_checks++; if (gnt !== 3'b000 || busy !== 1'b0) begin n_fail++; $display("FAIL rr_idle got gnt=%b busy=%b want 000/0", gnt, busy); end
        tick();
        n_checks++; if (gnt !== 3'b010) begin n_fail++; $display("FAIL rr_second got %b want 010", gnt); end
        req = 3'b101;
        repeat (3) tick();
        n_checks++; if (gnt !== 3'b100) begin n_fail++; $display("FAIL rr_third got %b want 100", gnt); end
        req = 3'b011;
        repeat (3) tick();
        n_checks++; if (gnt !== 3'b001) begin n_fail++; $display("FAIL rr_wrap got %b want 001", gnt); end
        req = 3'b000;
        repeat (2) tick();
        n_checks++; if (gnt !== 3'b000 || busy !== 1'b0) begin n_fail++; $display("FAIL rr_end got gnt=%b busy=%b", gnt, busy); end
        $display("test_round_robin done");
    endtask

    // Requester 1 writes; a stray strobe from 0 must not appear; clip limits.
    task automatic test_pixel_and_clip();
        req = 3'b010;
        tick();
        n_checks++; if (gnt !== 3'b010) begin n_fail++; $display("FAIL px_gnt got %b want 010", gnt); end
        x1 = 8'd10; y1 = 7'd20; colour1 = 3'b101; plot1 = 1'b1;
        x0 = 8'd99; y0 = 7'd33; colour0 = 3'b010; plot0 = 1'b1;
        tick();
        n_checks++; if (out_x !== 8'd10 || out_y !== 7'd20) begin n_fail++; $display("FAIL px_xy got %0d,%0d want 10,20", out_x, out_y); end
        n_checks++; if (out_colour !== 3'b101 || plot !== 1'b1) begin n_fail++; $display("FAIL px_colour_plot got %b/%b want 101/1", out_colour, plot); end
        plot1 = 1'b0;
        tick();
        n_checks++; if (plot !== 1'b0 || out_x !== 8'd10) begin n_fail++; $display("FAIL px_foreign got plot=%b x=%0d want 0/10", plot, out_x); end
        x1 = 8'd160; y1 = 7'd5; plot1 = 1'b1;
        tick();
        n_checks++; if (plot !== 1'b0 || out_x !== 8'd160) begin n_fail++; $display("FAIL clip_x got plot=%b x=%0d want 0/160", plot, out_x); end
        x1 = 8'd159; y1 = 7'd119;
        tick();
        n_checks++; if (plot !== 1'b1 || out_x !== 8'd159 || out_y !== 7'd119) begin n_fail++; $display("FAIL clip_edge got plot=%b x=%0d y=%0d want 1/159/119", plot, out_x, out_y); end
        x1 = 8'd0; y1 = 7'd120;
        tick();
        n_checks++; if (plot !== 1'b0 || out_y !== 7'd120) begin n_fail++; $display("FAIL clip_y got plot=%b y=%0d want 0/120", plot, out_y); end
        x1 = 8'd1; y1 = 7'd1;
        req = 3'b000;
        tick();
        n_checks++; if (plot !== 1'b0 || gnt !== 3'b000) begin n_fail++; $display("FAIL px_release got plot=%b gnt=%b want 0/000", plot, gnt); end
        plot0 = 1'b0; plot1 = 1'b0;
        tick();
        $display("test_pixel_and_clip done");
    endtask

    // Requester 0 drops while 2 raises in the same cycle: GAP, IDLE, then grant 2.
    task automatic test_back_to_back();
        req = 3'b001;
        tick();
        n_checks++; if (gnt !== 3'b001) begin n_fail++; $display("FAIL b2b_gnt0 got %b want 001", gnt); end
        tick();
        req = 3'b100;
        tick();
        n_checks++; if (gnt !== 3'b000 || busy !== 1'b1) begin n_fail++; $display("FAIL b2b_gap got gnt=%b busy=%b want 000/1", gnt, busy); end
        tick();
        n_checks++; if (gnt !== 3'b000 || busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle got gnt=%b busy=%b want 000/0", gnt, busy); end
        tick();
        n_checks++; if (gnt !== 3'b100) begin n_fail++; $display("FAIL b2b_gnt2 got %b want 100", gnt); end
        req = 3'b000;
        repeat (2) tick();
        $display("test_back_to_back done");
    endtask

    task automatic test_async_reset();
        req = 3'b001;
        x0 = 8'd50; y0 = 7'd60; colour0 = 3'b011; plot0 = 1'b1;
        tick();
        tick();
        n_checks++; if (out_x !== 8'd50 || plot !== 1'b1) begin n_fail++; $display("FAIL ar_pre got x=%0d plot=%b want 50/1", out_x, plot); end
        #2 reset = 1'b1;
        #1;
        n_checks++; if (gnt !== 3'b000 || plot !== 1'b0) begin n_fail++; $display("FAIL ar_gnt_plot got gnt=%b plot=%b want 000/0", gnt, plot); end
        n_checks++; if (out_x !== 8'd0 || out_y !== 7'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL ar_xy got x=%0d y=%0d busy=%b want 0/0/0", out_x, out_y, busy); end
        #1 reset = 1'b0;
        plot0 = 1'b0;
        req = 3'b110;
        tick();
        n_checks++; if (gnt !== 3'b010) begin n_fail++; $display("FAIL ar_restart got %b want 010", gnt); end
        req = 3'b000;
        repeat (2) tick();
        $display("test_async_reset done");
    endtask

    task automatic test_timeout();
        int held;
        int pulses;
        req = 3'b001;
        tick();
        held = 0;
        pulses = 0;
`ifdef PLOT_ARB_TIMEOUT_EN
        while (gnt === 3'b001 && held < 5000) begin
            held++;
            if (timeout === 1'b1) pulses++;
            tick();
        end
        n_checks++; if (held != 4096) begin n_fail++; $display("FAIL wd_len got %0d want 4096", held); end
        n_checks++; if (timeout !== 1'b1 || pulses != 0) begin n_fail++; $display("FAIL wd_pulse got timeout=%b early=%0d want 1/0", timeout, pulses); end
        tick();
        n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL wd_single got %b want 0", timeout); end
`else
        for (int i = 0; i < 10000; i++) begin
            if (gnt === 3'b001) held++;
            if (timeout !== 1'b0) pulses++;
            tick();
        end
        n_checks++; if (held != 10000) begin n_fail++; $display("FAIL hold_len got %0d want 10000", held); end
        n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL hold_timeout got %0d pulses want 0", pulses); end
`endif
        req = 3'b000;
        repeat (4) tick();
        $display("test_timeout done");
    endtask

    initial begin
        reset = 1'b0;
        req = 3'b000;
        x0 = 8'd0; x1 = 8'd0; x2 = 8'd0;
        y0 = 7'd0; y1 = 7'd0; y2 = 7'd0;
        colour0 = 3'd0; colour1 = 3'd0; colour2 = 3'd0;
        plot0 = 1'b0; plot1 = 1'b0; plot2 = 1'b0;
        test_reset();
        test_round_robin();
        test_pixel_and_clip();
        test_back_to_back();
        test_async_reset();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/plot_arbiter.md
PLOT_ARBITER -- requirements
Module: plot_arbiter

Interface
REQ-001 The module SHALL have port `clock`, input, 1 bit: single rising-edge clock for all state.
REQ-002 The module SHALL have port `reset`, input, 1 bit: asynchronous, active-high reset; clears all state immediately, independent of `clock`.
REQ-003 The module SHALL have port `req[2:0]`, input, 3 bits: per-requester drawing request, held high for the whole draw burst.
REQ-004 The module SHALL have ports `x0`/`x1`/`x2`, input, 8 bits each: requester pixel x coordinate.
REQ-005 The module SHALL have ports `y0`/`y1`/`y2`, input, 7 bits each: requester pixel y coordinate.
REQ-006 The module SHALL have ports `colour0`/`colour1`/`colour2`, input, 3 bits each: requester pixel colour.
REQ-007 The module SHALL have ports `plot0`/`plot1`/`plot2`, input, 1 bit each: requester pixel write strobe.
REQ-008 The module SHALL have port `gnt[2:0]`, output, 3 bits: registered grant, one-hot or zero.
REQ-009 The module SHALL have ports `out_x` (output, 8 bits), `out_y` (output, 7 bits), `out_colour` (output, 3 bits) and `plot` (output, 1 bit): registered write port to the VGA adapter.
REQ-010 The module SHALL have port `busy`, output, 1 bit: high whenever the FSM is not IDLE.
REQ-011 The module SHALL have port `timeout`, output, 1 bit: one-cycle pulse on forced grant revocation; tied 0 when the feature is compiled out (REQ-026).

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, GRANTED and GAP.
REQ-013 In IDLE with any `req` bit high, the next edge SHALL select a winner by round-robin, set `gnt` one-hot to the winner, and go to GRANTED. Latency from `req` sampled to `gnt` high is 1 cycle.
REQ-014 Round-robin search SHALL start at index (last_winner+1) mod 3 and proceed upward with wrap.
REQ-015 In IDLE with `req`==0, the FSM SHALL stay in IDLE with `gnt`=0 and `plot`=0.
REQ-016 In GRANTED with the winner's `req` high, each edge SHALL register the winner's x, y, colour and plot into `out_x`/`out_y`/`out_colour`/`plot`. Input-to-output latency is exactly 1 cycle.
REQ-017 Strobes from non-granted requesters SHALL be dropped; they are never queued or replayed.
REQ-018 Clipping: if the winner's x>159 or y>119, `plot` SHALL register 0, and `out_x`/`out_y`/`out_colour` SHALL still update.
REQ-019 In GRANTED, when the winner's `req` is sampled low, the next edge SHALL go to GAP with `gnt`=0 and `plot`=0. The winner's strobe in that cycle is ignored.
REQ-020 GAP SHALL last exactly one cycle, SHALL record last_winner, and SHALL always return to IDLE. This gives a minimum of 2 idle cycles between bursts.
REQ-021 Requests arriving while in GRANTED or GAP SHALL be served only through IDLE arbitration. If one requester drops `req` in the same cycle another raises it, GAP still occurs.
REQ-022 `gnt` SHALL never have more than one bit set; `plot` SHALL be 0 whenever `gnt`==0.

Reset
REQ-023 Asserting `reset` SHALL force, without waiting for a clock edge: state=IDLE, `gnt`=0, `plot`=0, `out_x`=0, `out_y`=0, `out_colour`=0, `busy`=0, `timeout`=0, timeout counter=0.
REQ-024 Reset SHALL set last_winner=2, so requester 0 has first priority after reset.
REQ-025 Reset asserted mid-burst SHALL abandon the burst; after release, arbitration restarts from REQ-024.

Configuration
REQ-026 Macro `PLOT_ARB_TIMEOUT_EN` SHALL control the watchdog.
- Defined: a 12-bit counter clears on entry to GRANTED and increments each GRANTED cycle. When it reaches 4095 while the winner's `req` is still high, the next edge forces GAP (`gnt`=0, `plot`=0) and pulses `timeout` high for 1 cycle. last_winner is updated as in REQ-020.
- Undefined: no counter is built, `timeout`=0 always, and a grant is held indefinitely.

Verification
REQ-027 Reset, then `req`=3'b111 -> `gnt`=3'b001 one cycle later; after its burst drops, `gnt`=3'b010; then 3'b100; then 3'b001.
REQ-028 Granted requester 1 drives x1=10, y1=20, colour1=3'b101, plot1=1 -> next cycle `out_x`=10, `out_y`=20, `out_colour`=3'b101, `plot`=1. Simultaneous plot0=1 produces no write.
REQ-029 Granted requester drives x=160, y=5, plot=1 -> `plot`=0 and `out_x`=160; x=159, y=119 -> `plot`=1.
REQ-030 Requester 0 drops `req` while requester 2 raises it in the same cycle -> 1 GAP cycle (`gnt`=0), 1 IDLE cycle, then `gnt`=3'b100.
REQ-031 Reset pulsed mid-burst between clock edges -> `gnt`, `plot`, `out_x`, `out_y` are 0 before the next edge; after release, `req`=3'b110 gives `gnt`=3'b010.
REQ-032 With `PLOT_ARB_TIMEOUT_EN`, requester 0 holds `req` high -> `gnt` drops after 4096 GRANTED cycles with a single `timeout` pulse. Without the macro, `gnt` stays 3'b001 for 10000 cycles.
